memory_controller: RTL
======================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have port clk_in, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_in, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port rdy_in, input, 1: low = hold every register and output.
REQ-004 SHALL have port clr_in, input, 1: misprediction flush.
REQ-005 SHALL have ports if_to_mc_ready (in, 1) and if_to_mc_PC (in, 32): instruction-fetch request and its address; held by requester until served.
REQ-006 SHALL have ports mc_to_if_ready (out, 1), mc_to_if_inst (out, 32) and mc_to_if_addr (out, 32): fetch-done pulse, instruction, address it belongs to.
REQ-007 SHALL have ports lsb_to_mc_valid (in, 1), lsb_to_mc_wr (in, 1; 1 = store), lsb_to_mc_addr (in, 32), lsb_to_mc_len (in, 2; 0 = 1 B, 1 = 2 B, 3 = 4 B), lsb_to_mc_data (in, 32): data request held until served.
REQ-008 SHALL have ports mc_to_lsb_ready (out, 1) and mc_to_lsb_data (out, 32): data-done pulse, zero-extended load data.
REQ-009 SHALL have ports mem_din (in, 8), mem_dout (out, 8), mem_a (out, 32), mem_wr (out, 1; 1 = write) and io_buffer_full (in, 1): byte RAM port; read byte appears on mem_din one cycle after mem_a is registered.

Function
REQ-010 SHALL implement states IDLE, IFETCH, LOAD, STORE, DONE.
REQ-011 In IDLE, a request present at an edge SHALL be accepted; LSB request SHALL have priority over IF request when both are present.
REQ-012 Acceptance edge SHALL latch address, length (4 for IF), store data and a byte counter = 0, and SHALL move to IFETCH, LOAD or STORE.
REQ-013 Reads of n bytes: mem_a SHALL present addr+k at edges k = 0..n-1 after acceptance (edge 0 = acceptance edge), mem_wr = 0.
REQ-014 Reads: byte k SHALL be captured from mem_din at edge k+2 into bits [8k+7:8k] (little-endian); unrequested upper bits SHALL be 0.
REQ-015 Reads: ready output (mc_to_if_ready or mc_to_lsb_ready) SHALL be registered high at edge n+1, i.e. IF fetch ready visible the cycle after edge 5; result and mc_to_if_addr valid that same cycle.
REQ-016 Stores of n bytes: at edges k = 0..n-1, mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr = 1; mem_wr SHALL return to 0 at the edge after the last byte, at which mc_to_lsb_ready is registered high.
REQ-017 Every ready pulse SHALL last exactly one cycle; state SHALL pass through DONE for exactly one cycle, where no request is accepted.
REQ-018 Store with addr[17:16] == 2'b11 while io_buffer_full = 1: mem_wr SHALL be 0 and the byte counter SHALL not advance; resume when io_buffer_full = 0.
REQ-019 clr_in = 1 during IFETCH or LOAD: abort, state to IDLE, mem_wr = 0, no ready pulse; requests present that cycle SHALL not be accepted.
REQ-020 clr_in = 1 during STORE: store SHALL complete all bytes and deliver its ready pulse (committed store).
REQ-021 clr_in = 1 in DONE: any ready pulse already registered SHALL be suppressed (forced 0 next edge).
REQ-022 Address increment SHALL be 32-bit modular (0xFFFFFFFF+1 = 0).
REQ-023 rdy_in = 0 SHALL freeze everything including the byte counter; clr_in and requests ignored while frozen.

Reset
REQ-024 rst_in = 0 at an edge SHALL set state IDLE, counter 0, mem_wr 0, mem_a 0, mem_dout 0, both ready outputs 0, mc_to_if_inst 0, mc_to_if_addr 0, mc_to_lsb_data 0, overriding rdy_in and clr_in.
REQ-025 Reset mid-transfer SHALL abandon the transfer without a ready pulse; the first request after release SHALL be accepted on the first edge with rst_in = 1.

Verification
REQ-026 IF request PC=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> mem_a 0x100..0x103 on edges 0..3, mc_to_if_inst = 0x00100513, mc_to_if_addr = 0x100, ready one cycle after edge 5.
REQ-027 IF and LSB load (addr 0x2002, len 1) requested same cycle -> load served first, mc_to_lsb_data = 0x0000BBAA from bytes 0xAA,0xBB; IF accepted after DONE.
REQ-028 Store 0x30000, len 0, data 0x41, io_buffer_full high 3 cycles -> mem_wr held 0 those cycles, then single write 0x41, mc_to_lsb_ready one cycle.
REQ-029 clr_in at edge 2 of IF fetch -> no mc_to_if_ready; next accepted request restarts cleanly with counter 0.
REQ-030 clr_in during 4-byte store 0x1000 data 0xDEADBEEF -> bytes EF,BE,AD,DE written to 0x1000..0x1003, ready pulse delivered.
REQ-031 rst_in low during LOAD, rdy_in low across cycles mid-fetch -> all outputs reset values; frozen fetch resumes with identical result.

Source files
------------

// File: rtl/memory_controller.sv
// Byte-serial memory controller: arbitrates instruction-fetch and load/store
// requests onto a single 8-bit RAM port with one-cycle read latency.
module memory_controller (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        if_to_mc_ready,
  input  logic [31:0] if_to_mc_PC,
  output logic        mc_to_if_ready,
  output logic [31:0] mc_to_if_inst,
  output logic [31:0] mc_to_if_addr,
  input  logic        lsb_to_mc_valid,
  input  logic        lsb_to_mc_wr,
  input  logic [31:0] lsb_to_mc_addr,
  input  logic [1:0]  lsb_to_mc_len,
  input  logic [31:0] lsb_to_mc_data,
  output logic        mc_to_lsb_ready,
  output logic [31:0] mc_to_lsb_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, DONE} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] base, base_n;
  logic [1:0]  last, last_n;
  logic [31:0] wdata, wdata_n;
  logic [31:0] rbuf, rbuf_n;
  logic [31:0] mem_a_n;
  logic [7:0]  mem_dout_n;
  logic        mem_wr_n;
  logic        if_rdy_n, lsb_rdy_n;
  logic [31:0] inst_n, if_addr_n, lsb_data_n;

  logic [7:0]  din_hold;
  logic        hold_valid;
  logic [7:0]  din_eff;
  logic [2:0]  cnt_inc, nxt, span;
  logic [1:0]  lane;
  logic        io_stall, acc_stall;

  // The RAM keeps running while rdy_in is low, so the byte due at the first
  // frozen edge is parked here and consumed on the resume edge.
  assign din_eff   = hold_valid ? din_hold : mem_din;
  assign cnt_inc   = cnt + 3'd1;
  assign span      = {1'b0, last} + 3'd1;
  assign nxt       = mem_wr ? cnt_inc : cnt;
  assign lane      = cnt[1:0] - 2'd1;
  assign io_stall  = (base[17:16] == 2'b11) && io_buffer_full;
  assign acc_stall = (lsb_to_mc_addr[17:16] == 2'b11) && io_buffer_full;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    base_n     = base;
    last_n     = last;
    wdata_n    = wdata;
    rbuf_n     = rbuf;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n   = 1'b0;
    if_rdy_n   = 1'b0;
    lsb_rdy_n  = 1'b0;
    inst_n     = mc_to_if_inst;
    if_addr_n  = mc_to_if_addr;
    lsb_data_n = mc_to_lsb_data;

    unique case (state)
      IDLE: begin
        if (!clr_in) begin
          if (lsb_to_mc_valid) begin
            base_n  = lsb_to_mc_addr;
            last_n  = lsb_to_mc_len;
            wdata_n = lsb_to_mc_data;
            cnt_n   = '0;
            rbuf_n  = '0;
            mem_a_n = lsb_to_mc_addr;
            if (lsb_to_mc_wr) begin
              state_n = STORE;
              if (!acc_stall) begin
                mem_wr_n   = 1'b1;
                mem_dout_n = lsb_to_mc_data[7:0];
              end
            end else begin
              state_n = LOAD;
            end
          end else if (if_to_mc_ready) begin
            base_n  = if_to_mc_PC;
            last_n  = 2'd3;
            cnt_n   = '0;
            rbuf_n  = '0;
            mem_a_n = if_to_mc_PC;
            state_n = IFETCH;
          end
        end
      end

      IFETCH, LOAD: begin
        if (clr_in) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          if (cnt < {1'b0, last}) mem_a_n = base + {29'd0, cnt_inc};
          if (cnt != 3'd0) rbuf_n[{lane, 3'b000} +: 8] = din_eff;
          if (cnt == span) begin
            state_n = DONE;
            if (state == IFETCH) begin
              if_rdy_n  = 1'b1;
              inst_n    = rbuf_n;
              if_addr_n = base;
            end else begin
              lsb_rdy_n  = 1'b1;
              lsb_data_n = rbuf_n;
            end
          end
        end
      end

      STORE: begin
        // Committed: clr_in is deliberately ignored until the last byte lands.
        cnt_n = nxt;
        if (nxt == span) begin
          state_n   = DONE;
          lsb_rdy_n = 1'b1;
        end else if (!io_stall) begin
          mem_a_n    = base + {29'd0, nxt};
          mem_dout_n = wdata[{nxt[1:0], 3'b000} +: 8];
          mem_wr_n   = 1'b1;
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt             <= '0;
      base            <= '0;
      last            <= '0;
      wdata           <= '0;
      rbuf            <= '0;
      mem_a           <= '0;
      mem_dout        <= '0;
      mem_wr          <= 1'b0;
      mc_to_if_ready  <= 1'b0;
      mc_to_lsb_ready <= 1'b0;
      mc_to_if_inst   <= '0;
      mc_to_if_addr   <= '0;
      mc_to_lsb_data  <= '0;
    end else if (rdy_in) begin
      cnt             <= cnt_n;
      base            <= base_n;
      last            <= last_n;
      wdata           <= wdata_n;
      rbuf            <= rbuf_n;
      mem_a           <= mem_a_n;
      mem_dout        <= mem_dout_n;
      mem_wr          <= mem_wr_n;
      mc_to_if_ready  <= if_rdy_n;
      mc_to_lsb_ready <= lsb_rdy_n;
      mc_to_if_inst   <= inst_n;
      mc_to_if_addr   <= if_addr_n;
      mc_to_lsb_data  <= lsb_data_n;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      din_hold   <= '0;
      hold_valid <= 1'b0;
    end else if (!rdy_in) begin
      if (!hold_valid) begin
        din_hold   <= mem_din;
        hold_valid <= 1'b1;
      end
    end else begin
      hold_valid <= 1'b0;
    end
  end

endmodule
